spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 147 ++++++++++++++
 tb/tb_spi_master.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// rtl/spi_master.sv - single-clock SPI master: 10-bit command frame out, optional byte read back
module spi_master #(
    parameter int TURN = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] wdata,
    output logic       MOSI,
    input  logic       MISO,
    output logic       SS_N,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       rdata_valid
);

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        SHIFT,
        TURN_WAIT,
        RX,
        END
    } state_t;

    localparam logic [3:0] SHIFT_LAST = 4'd9;
    localparam logic [3:0] TURN_LAST  = 4'(TURN - 1);
    localparam logic [3:0] RX_LAST    = 4'd7;

    state_t     state;
    logic [9:0] frame;
    logic       is_read;
    logic [3:0] cnt;
    logic [6:0] rx_sh;
    logic       mosi_q;
    logic       ss_n_q;
    logic       busy_q;
    logic       done_q;
    logic [7:0] rdata_q;
    logic       rdata_valid_q;

    assign MOSI        = mosi_q;
    assign SS_N        = ss_n_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;

    // Transfer sequencer; every output is registered alongside the state it belongs to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            frame         <= 10'd0;
            is_read       <= 1'b0;
            cnt           <= 4'd0;
            rx_sh         <= 7'd0;
            mosi_q        <= 1'b0;
            ss_n_q        <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            rdata_q       <= 8'h00;
            rdata_valid_q <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            rdata_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    ss_n_q <= 1'b1;
                    mosi_q <= 1'b0;
                    busy_q <= 1'b0;
                    cnt    <= 4'd0;
                    if (start) begin
                        // The frame is captured here so later cmd/wdata changes are harmless
                        frame   <= {cmd, wdata};
                        is_read <= (cmd == 2'b11);
                        state   <= SEL;
                        ss_n_q  <= 1'b0;
                        mosi_q  <= cmd[1];
                        busy_q  <= 1'b1;
                    end
                end
                SEL: begin
                    state  <= SHIFT;
                    mosi_q <= frame[9];
                    frame  <= {frame[8:0], 1'b0};
                    cnt    <= 4'd0;
                end
                SHIFT: begin
                    if (cnt == SHIFT_LAST) begin
                        cnt    <= 4'd0;
                        mosi_q <= 1'b0;
                        if (is_read) begin
                            state <= TURN_WAIT;
                        end else begin
                            state  <= END;
                            ss_n_q <= 1'b1;
                            done_q <= 1'b1;
                        end
                    end else begin
                        mosi_q <= frame[9];
                        frame  <= {frame[8:0], 1'b0};
                        cnt    <= cnt + 4'd1;
                    end
                end
                TURN_WAIT: begin
                    mosi_q <= 1'b0;
                    if (cnt == TURN_LAST) begin
                        cnt   <= 4'd0;
                        state <= RX;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RX: begin
                    // The eighth sample goes straight into rdata, so only seven bits are held
                    rx_sh <= {rx_sh[5:0], MISO};
                    if (cnt == RX_LAST) begin
                        cnt           <= 4'd0;
                        state         <= END;
                        ss_n_q        <= 1'b1;
                        done_q        <= 1'b1;
                        rdata_q       <= {rx_sh, MISO};
                        rdata_valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                END: begin
                    state   <= IDLE;
                    busy_q  <= 1'b0;
                    ss_n_q  <= 1'b1;
                    mosi_q  <= 1'b0;
                    is_read <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    ss_n_q <= 1'b1;
                    mosi_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - scoreboard bench for spi_master with a behavioural slave and RAM
module tb_spi_master;

    localparam int TURN = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [7:0] wdata = 8'h00;
    logic       MISO = 1'b0;
    logic       MOSI;
    logic       SS_N;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       rdata_valid;

    spi_master #(.TURN(TURN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cmd        (cmd),
        .wdata      (wdata),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .SS_N       (SS_N),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .rdata_valid(rdata_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: what the slave RAM should hold and what each transfer looks like
    typedef struct {
        logic [10:0] mosi;
        int          low_len;
        bit          is_read;
        logic [7:0]  rdata;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] ref_mem[256];
    logic [7:0] ref_wa = 8'h00;
    logic [7:0] ref_ra = 8'h00;
    logic [7:0] ref_rdata = 8'h00;

    task automatic push_exp(input logic [1:0] c, input logic [7:0] d);
        exp_t e;
        case (c)
            2'b00: ref_wa = d;
            2'b01: ref_mem[ref_wa] = d;
            2'b10: ref_ra = d;
            default: ref_rdata = ref_mem[ref_ra];
        endcase
        e.mosi    = {c[1], c, d};
        e.low_len = (c == 2'b11) ? 19 + TURN : 11;
        e.is_read = (c == 2'b11);
        e.rdata   = ref_rdata;
        expq.push_back(e);
    endtask

    // Slave BFM: decodes the frame off MOSI and returns RAM data on MISO during RX
    logic [7:0]  slv_mem[256];
    logic [7:0]  slv_wa = 8'h00;
    logic [7:0]  slv_ra = 8'h00;
    logic [7:0]  slv_tx = 8'h00;
    logic [10:0] slv_bits = 11'd0;
    int          slv_k = 0;

    always @(negedge clk) begin
        if (!rst_n || SS_N) begin
            slv_k    = 0;
            slv_bits = 11'd0;
            MISO     = 1'b0;
        end else begin
            if (slv_k < 11) slv_bits = {slv_bits[9:0], MOSI};
            if (slv_k == 10) begin
                case (slv_bits[9:8])
                    2'b00: slv_wa = slv_bits[7:0];
                    2'b01: slv_mem[slv_wa] = slv_bits[7:0];
                    2'b10: slv_ra = slv_bits[7:0];
                    default: slv_tx = slv_mem[slv_ra];
                endcase
            end
            if (slv_k >= 11 + TURN && slv_k < 19 + TURN)
                MISO = slv_tx[7 - (slv_k - 11 - TURN)];
            else
                MISO = 1'b0;
            slv_k++;
        end
    end

    // Monitor: measures each transfer on the wire and scores it when done pulses
    int          mon_low = 0;
    int          mon_busy = 0;
    logic [10:0] mon_cap = 11'd0;
    logic        mon_extra = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            mon_low   = 0;
            mon_busy  = 0;
            mon_cap   = 11'd0;
            mon_extra = 1'b0;
        end else begin
            if (!SS_N) begin
                if (mon_low < 11) mon_cap = {mon_cap[9:0], MOSI};
                else mon_extra = mon_extra | MOSI;
                mon_low++;
            end
            if (busy) mon_busy++;
            if (rdata_valid) check("rdata_valid_with_done", int'(done), 1);
            if (done) begin
                n_cmp++;
                if (expq.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 expected no transfer pending");
                end else begin
                    e = expq.pop_front();
                    check("mosi_frame", int'(mon_cap), int'(e.mosi));
                    check("ss_n_low_cycles", mon_low, e.low_len);
                    check("mosi_zero_after_frame", int'(mon_extra), 0);
                    check("busy_cycles", mon_busy, e.low_len + 1);
                    check("rdata_valid", int'(rdata_valid), int'(e.is_read));
                    check("rdata", int'(rdata), int'(e.rdata));
                end
                mon_low   = 0;
                mon_busy  = 0;
                mon_extra = 1'b0;
            end
        end
    end

    // One transfer; ign adds stray start pulses in SHIFT and in END
    task automatic issue(input logic [1:0] c, input logic [7:0] d, input bit ign);
        int i;
        @(negedge clk);
        start = 1'b1;
        cmd   = c;
        wdata = d;
        push_exp(c, d);
        @(negedge clk);
        start = 1'b0;
        cmd   = 2'($urandom);
        wdata = 8'($urandom);
        i = 0;
        while (!done && i < 60) begin
            if (ign) start = (i == 3);
            @(negedge clk);
            i++;
        end
        start = 1'b0;
        check("done_within_budget", int'(done), 1);
        if (ign) begin
            start = 1'b1;
            cmd   = 2'b11;
            wdata = 8'($urandom);
            @(negedge clk);
            start = 1'b0;
            check("idle_busy_after_end", int'(busy), 0);
            check("idle_ss_n_after_end", int'(SS_N), 1);
            @(negedge clk);
            check("end_start_ignored_busy", int'(busy), 0);
            check("end_start_ignored_ss_n", int'(SS_N), 1);
        end
    endtask

    initial begin
        logic [1:0] rc;
        logic [7:0] rd;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'h00;
            slv_mem[i] = 8'h00;
        end

        repeat (3) @(negedge clk);
        check("reset_ss_n", int'(SS_N), 1);
        check("reset_mosi", int'(MOSI), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_rdata", int'(rdata), 0);
        check("reset_rdata_valid", int'(rdata_valid), 0);
        rst_n = 1'b1;

        // Abort a read-data transfer in its fifth SHIFT cycle
        @(negedge clk);
        start = 1'b1;
        cmd   = 2'b11;
        wdata = 8'h3C;
        @(negedge clk);
        start = 1'b0;
        check("abort_ss_n_low_in_sel", int'(SS_N), 0);
        repeat (5) @(negedge clk);
        check("abort_ss_n_low_in_shift", int'(SS_N), 0);
        rst_n = 1'b0;
        #1;
        check("abort_ss_n_async", int'(SS_N), 1);
        check("abort_busy_async", int'(busy), 0);
        check("abort_mosi_async", int'(MOSI), 0);
        check("abort_done", int'(done), 0);
        repeat (2) @(negedge clk);
        check("abort_rdata_kept", int'(rdata), 0);
        check("abort_rdata_valid", int'(rdata_valid), 0);
        rst_n = 1'b1;

        // Loopback through the slave RAM, then a known MISO pattern
        issue(2'b00, 8'hDD, 1'b0);
        issue(2'b01, 8'hAA, 1'b0);
        issue(2'b10, 8'hDD, 1'b0);
        issue(2'b11, 8'h5C, 1'b0);
        issue(2'b00, 8'h10, 1'b0);
        issue(2'b01, 8'hA5, 1'b0);
        issue(2'b10, 8'h10, 1'b0);
        issue(2'b11, 8'hE7, 1'b0);

        // Stray starts during SHIFT and END
        issue(2'b01, 8'h5A, 1'b1);
        issue(2'b11, 8'h00, 1'b1);

        // Random traffic over a small address window so reads hit earlier writes
        for (int n = 0; n < 40; n++) begin
            rc = 2'($urandom);
            rd = (rc == 2'b00 || rc == 2'b10) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            issue(rc, rd, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
